mux_rr_arbiter: RTL and testbench

- Shares one W-bit output channel between N requesters, using a round-robin arbiter that drives an N:1 multiplexer select.
- Each requester hands over one beat per valid/ready transfer. The winning beat is captured into a single-entry output register, which holds it until the consumer accepts it.
- Sits between several producer blocks and one shared downstream consumer. It is the sequencing and sharing layer for the 2:1/N:1 multiplexer datapath.

---
 rtl/mux_rr_arbiter.sv | 96 +++++++++
 tb/tb_mux_rr_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// Round-robin N:1 channel multiplexer with a single-entry registered output.
// The winner among the valid requesters (scanned from last_gnt+1, wrapping) is
// granted whenever the output register is empty or being drained this cycle.
module mux_rr_arbiter #(
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int SEL_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     in_valid,
    input  logic [N*W-1:0]   in_data,
    output logic [N-1:0]     in_ready,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic [SEL_W-1:0] out_sel,
    input  logic             out_ready,
    output logic [SEL_W-1:0] last_gnt
);

    localparam int unsigned NU = N;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [W-1:0]     data_n;
    logic [SEL_W-1:0] sel_n;
    logic [SEL_W-1:0] gnt_n;
    logic [SEL_W-1:0] cand;
    logic [SEL_W-1:0] win_idx;
    logic             win_found;
    logic             can_accept;
    logic             transfer;

    assign out_valid = (state == FULL);

    // Priority scan starting just after the most recent grant, wrapping modulo N.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= NU; k++) begin
            cand = SEL_W'((32'(last_gnt) + k) % NU);
            if (!win_found && in_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Grant the winner only when the output register can take a beat; the reset
    // term keeps in_ready low during the reset cycle itself.
    always_comb begin
        can_accept = !out_valid || out_ready;
        in_ready   = '0;
        if (rst_n && win_found && can_accept) begin
            in_ready[win_idx] = 1'b1;
        end
        transfer = |(in_valid & in_ready);
    end

    // Next-state and next-register values: refill on transfer, drain otherwise.
    always_comb begin
        state_n = state;
        data_n  = out_data;
        sel_n   = out_sel;
        gnt_n   = last_gnt;
        if (transfer) begin
            state_n = FULL;
            data_n  = in_data[win_idx*W +: W];
            sel_n   = win_idx;
            gnt_n   = win_idx;
        end else if (out_valid && out_ready) begin
            state_n = EMPTY;
        end
    end

    // State and output register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= EMPTY;
            out_data <= '0;
            out_sel  <= '0;
            last_gnt <= SEL_W'(N - 1);
        end else begin
            state    <= state_n;
            out_data <= data_n;
            out_sel  <= sel_n;
            last_gnt <= gnt_n;
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed self-checking bench for mux_rr_arbiter (N=4, W=8).
module tb_mux_rr_arbiter;

    localparam int N = 4;
    localparam int W = 8;
    localparam int SEL_W = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     in_valid;
    logic [N*W-1:0]   in_data;
    logic [N-1:0]     in_ready;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic [SEL_W-1:0] out_sel;
    logic             out_ready;
    logic [SEL_W-1:0] last_gnt;

    int checks = 0;
    int errors = 0;

    mux_rr_arbiter #(.N(N), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_sel(out_sel), .out_ready(out_ready), .last_gnt(last_gnt)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Advance to 1 ns after the next rising edge (registered outputs stable).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bring the DUT to its reset state with idle inputs.
    task automatic do_reset();
        rst_n = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b1;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < N; i++) in_data[i*W +: W] = 8'hE0 + 8'(i);
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready cyc%0d got %b exp 0000", c, in_ready); end
            tick();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
            checks++; if (last_gnt !== 2'd3) begin errors++; $display("FAIL reset_last_gnt got %0d exp 3", last_gnt); end
            checks++; if (out_data !== 8'h00 || out_sel !== 2'd0) begin errors++; $display("FAIL reset_out_regs got %h/%0d exp 00/0", out_data, out_sel); end
        end
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_grant got %b exp 0001", in_ready); end
        in_valid = '0;
        tick();
    endtask

    task automatic test_single();
        do_reset();
        in_valid = 4'b0100; in_data[2*W +: W] = 8'hA5; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL single_in_ready got %b exp 0100", in_ready); end
        tick();
        in_valid = '0;
        checks++; if (out_valid !== 1'b1 || out_data !== 8'hA5) begin errors++; $display("FAIL single_out got v=%b d=%h exp v=1 d=a5", out_valid, out_data); end
        checks++; if (out_sel !== 2'd2 || last_gnt !== 2'd2) begin errors++; $display("FAIL single_sel got sel=%0d gnt=%0d exp 2/2", out_sel, last_gnt); end
        tick();
        checks++; if (out_valid !== 1'b0 || out_data !== 8'hA5 || last_gnt !== 2'd2) begin errors++; $display("FAIL single_drain got v=%b d=%h gnt=%0d exp 0/a5/2", out_valid, out_data, last_gnt); end
    endtask

    task automatic test_contention();
        logic [W-1:0] exp_d;
        do_reset();
        in_valid = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < N; i++) in_data[i*W +: W] = 8'h10 + 8'(i);
        for (int k = 0; k < 8; k++) begin
            tick();
            exp_d = 8'h10 + 8'(k % N);
            checks++; if (out_valid !== 1'b1 || out_data !== exp_d || out_sel !== 2'(k % N)) begin
                errors++; $display("FAIL contention_beat%0d got v=%b d=%h sel=%0d exp v=1 d=%h sel=%0d", k, out_valid, out_data, out_sel, exp_d, k % N);
            end
        end
        in_valid = '0;
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        in_valid = 4'b0010; in_data[1*W +: W] = 8'h3C; out_ready = 1'b1;
        tick();
        in_valid = 4'b1001; in_data[0 +: W] = 8'h50; in_data[3*W +: W] = 8'h53; out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL stall_in_ready cyc%0d got %b exp 0000", c, in_ready); end
            tick();
            checks++; if (out_valid !== 1'b1 || out_data !== 8'h3C || out_sel !== 2'd1 || last_gnt !== 2'd1) begin
                errors++; $display("FAIL stall_hold cyc%0d got v=%b d=%h sel=%0d gnt=%0d exp 1/3c/1/1", c, out_valid, out_data, out_sel, last_gnt);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b1000) begin errors++; $display("FAIL stall_release_grant got %b exp 1000", in_ready); end
        tick();
        in_valid = '0;
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h53 || out_sel !== 2'd3) begin errors++; $display("FAIL stall_release_beat got v=%b d=%h sel=%0d exp 1/53/3", out_valid, out_data, out_sel); end
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        in_valid = 4'b1001; in_data[0 +: W] = 8'h60; in_data[3*W +: W] = 8'h63; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL wrap_first_grant got %b exp 0001", in_ready); end
        tick();
        checks++; if (out_data !== 8'h60 || out_sel !== 2'd0) begin errors++; $display("FAIL wrap_first_beat got d=%h sel=%0d exp 60/0", out_data, out_sel); end
        #1;
        checks++; if (in_ready !== 4'b1000) begin errors++; $display("FAIL wrap_second_grant got %b exp 1000", in_ready); end
        tick();
        in_valid = '0;
        checks++; if (out_data !== 8'h63 || out_sel !== 2'd3 || last_gnt !== 2'd3) begin errors++; $display("FAIL wrap_second_beat got d=%h sel=%0d gnt=%0d exp 63/3/3", out_data, out_sel, last_gnt); end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        in_valid = 4'b0100; in_data[2*W +: W] = 8'h77; out_ready = 1'b1;
        tick();
        in_valid = 4'b1111; out_ready = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b1 || last_gnt !== 2'd2) begin errors++; $display("FAIL midrst_setup got v=%b gnt=%0d exp 1/2", out_valid, last_gnt); end
        rst_n = 1'b0; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL midrst_in_ready got %b exp 0000", in_ready); end
        tick();
        rst_n = 1'b1; in_valid = '0;
        checks++; if (out_valid !== 1'b0 || last_gnt !== 2'd3) begin errors++; $display("FAIL midrst_state got v=%b gnt=%0d exp 0/3", out_valid, last_gnt); end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_beat cyc%0d got v=%b exp 0", c, out_valid); end
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_wrap();
        test_reset_mid_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog: the directed sequence is far shorter than this bound.
    initial begin
        #100000;
        $display("FAIL watchdog timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
